par_serial_lane: RTL and testbench



---
 rtl/phy_tx_pkg.sv | 25 ++
 rtl/par_serial_lane_if.sv | 27 ++
 rtl/par_serial_lane.sv | 62 ++++++
 tb/tb_par_serial_lane.sv | 138 +++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared PHY TX/RX lane definitions: alignment/idle symbols and lane state.
// The RX deserializer reuses COM and IDLE for comma detection.
package phy_tx_pkg;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } lane_state_e;

  // Byte placed in the shift register at a byte boundary.
  function automatic logic [7:0] lane_load_byte(input lane_state_e state,
                                                input logic        valid,
                                                input logic [7:0]  data);
    logic [7:0] b;
    b = COM;
    if (state == ACTIVE) begin
      b = valid ? data : IDLE;
    end
    return b;
  endfunction

endpackage

// File: rtl/par_serial_lane_if.sv
// Lane handshake between the byte striper (master) and the serializer (slave).
interface par_serial_lane_if;
  import phy_tx_pkg::*;

  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       byte_req;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  byte_req,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output byte_req,
    output active
  );

endinterface

// File: rtl/par_serial_lane.sv
// Per-lane parallel-to-serial converter: SYNC_BYTES COM bytes after reset,
// then lane data (or IDLE) shifted out MSB-first, one bit per clk_8f.
module par_serial_lane
  import phy_tx_pkg::*;
#(
  parameter int SYNC_BYTES = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  par_serial_lane_if.slave lane
);

  localparam int SYNC_W = (SYNC_BYTES < 1) ? 1 : $clog2(SYNC_BYTES + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);
  localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);

  logic [7:0]        shift_reg_q, shift_reg_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  lane_state_e       state_q,     state_d;
  logic [SYNC_W-1:0] sync_cnt_q,  sync_cnt_d;
  logic              load;

  // bit_cnt==7 marks the last bit of the current byte; the next edge loads.
  assign load = (bit_cnt_q == 3'd7);

  always_comb begin
    shift_reg_d = {shift_reg_q[6:0], 1'b0};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;

    if (load) begin
      shift_reg_d = lane_load_byte(state_q, lane.valid_in, lane.data_in);
      if (state_q == SYNC) begin
        sync_cnt_d = sync_cnt_q + SYNC_ONE;
        // Last COM load flips to ACTIVE so the next boundary samples data.
        if (sync_cnt_q == SYNC_LAST) begin
          state_d = ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      shift_reg_q <= 8'h00;
      bit_cnt_q   <= 3'd7;
      state_q     <= SYNC;
      sync_cnt_q  <= '0;
    end else begin
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  assign lane.data_out = shift_reg_q[7];
  assign lane.byte_req = load;
  assign lane.active   = (state_q == ACTIVE);

endmodule

// File: tb/tb_par_serial_lane.sv
// Bench for par_serial_lane: two lanes (SYNC_BYTES=4 and 1) driven in lockstep
// and compared against a byte-stream reference model.
module tb_par_serial_lane;
  import phy_tx_pkg::*;

  localparam int SB0 = 4;
  localparam int SB1 = 1;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_8f = ~clk_8f;

  par_serial_lane_if if0 ();
  par_serial_lane_if if1 ();

  par_serial_lane #(.SYNC_BYTES(SB0)) dut0 (.clk_8f(clk_8f), .reset(reset), .lane(if0.slave));
  par_serial_lane #(.SYNC_BYTES(SB1)) dut1 (.clk_8f(clk_8f), .reset(reset), .lane(if1.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: edges since release, bytes started, byte on the wire.
  int         e_cnt [2];
  int         nbytes[2];
  logic [7:0] cur   [2];
  int         sbytes[2] = '{SB0, SB1};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic check_lane(input int d, input logic dout, input logic breq, input logic act);
    logic od, ob, oa;
    if (d == 0) begin
      od = if0.data_out; ob = if0.byte_req; oa = if0.active;
    end else begin
      od = if1.data_out; ob = if1.byte_req; oa = if1.active;
    end
    chk($sformatf("lane%0d_data_out_e%0d", d, e_cnt[d]), {7'b0, od}, {7'b0, dout});
    chk($sformatf("lane%0d_byte_req_e%0d", d, e_cnt[d]), {7'b0, ob}, {7'b0, breq});
    chk($sformatf("lane%0d_active_e%0d",   d, e_cnt[d]), {7'b0, oa}, {7'b0, act});
  endtask

  // One clk_8f edge with the given upstream inputs, then model update and checks.
  task automatic tick(input logic [7:0] dat, input logic v);
    int pos [2];
    if0.data_in = dat; if0.valid_in = v;
    if1.data_in = dat; if1.valid_in = v;
    @(posedge clk_8f);
    for (int d = 0; d < 2; d++) begin
      e_cnt[d]++;
      pos[d] = (e_cnt[d] - 1) % 8;
      if (pos[d] == 0) begin
        if (nbytes[d] < sbytes[d]) cur[d] = COM;
        else                       cur[d] = v ? dat : IDLE;
        nbytes[d]++;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_lane(d, cur[d][7 - pos[d]], (e_cnt[d] % 8) == 0, nbytes[d] >= sbytes[d]);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      e_cnt[d] = 0; nbytes[d] = 0; cur[d] = 8'h00;
    end
    #1;
    for (int d = 0; d < 2; d++) check_lane(d, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk_8f);
    #1;
    for (int d = 0; d < 2; d++) check_lane(d, 1'b0, 1'b1, 1'b0);
    @(negedge clk_8f);
    reset = 1'b0;
  endtask

  // Idle until the model says the next edge is a byte boundary.
  task automatic align_to_boundary();
    while ((e_cnt[0] % 8) != 0) tick(8'h00, 1'b0);
  endtask

  initial begin
    if0.data_in = 8'h00; if0.valid_in = 1'b0;
    if1.data_in = 8'h00; if1.valid_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      e_cnt[d] = 0; nbytes[d] = 0; cur[d] = 8'h00;
    end

    // Power-on reset state
    reset = 1'b1;
    @(posedge clk_8f);
    #1;
    for (int d = 0; d < 2; d++) check_lane(d, 1'b0, 1'b1, 1'b0);
    @(negedge clk_8f);
    reset = 1'b0;

    // Sync then IDLE with valid_in low
    repeat (48) tick(8'h00, 1'b0);

    // Valid 0x55 during SYNC must be dropped by the SYNC_BYTES=4 lane
    apply_reset();
    repeat (40) tick(8'h55, 1'b1);

    // Directed bytes: 0xA5, then back-to-back 0x01, 0xFF, then idle
    align_to_boundary();
    tick(8'hA5, 1'b1);
    repeat (7) tick(8'h00, 1'b0);
    tick(8'h01, 1'b1);
    repeat (7) tick(8'h01, 1'b1);
    tick(8'hFF, 1'b1);
    repeat (7) tick(8'hFF, 1'b1);
    repeat (16) tick(8'h00, 1'b0);

    // Randomized data/valid every cycle
    repeat (240) tick(8'($urandom), 1'($urandom));

    // Reset in the middle of 0xA5, then the full sequence again
    align_to_boundary();
    tick(8'hA5, 1'b1);
    repeat (3) tick(8'h00, 1'b0);
    apply_reset();
    repeat (40) tick(8'h3C, 1'b1);
    repeat (160) tick(8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
